mux_sel_seq: RTL and testbench

Select-line sequencer for the 2:1 multiplexer lab stage. It sits directly upstream of the MUX and drives its `s` input. It time-shares the output between channel a and channel b under a fixed dwell period, skips channels that are not requesting, and supports freeze (`hold`) and disable (`en`). With default parameters and both channels requesting, `s` toggles every 20 clocks.

---
 rtl/mux_sel_seq_if.sv | 33 +++
 rtl/mux_sel_seq.sv | 88 ++++++++
 tb/tb_mux_sel_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mux_sel_seq_if.sv
// Handshake bundle between the select-line sequencer and whatever drives its requests.
// The master side owns the control/request lines; the sequencer (slave) owns the select outputs.
interface mux_sel_seq_if #(
    parameter int CW = 8
);
    logic          en;
    logic          hold;
    logic          req_a;
    logic          req_b;
    logic          s;
    logic          sw;
    logic [CW-1:0] cnt;

    modport master (
        output en,
        output hold,
        output req_a,
        output req_b,
        input  s,
        input  sw,
        input  cnt
    );

    modport slave (
        input  en,
        input  hold,
        input  req_a,
        input  req_b,
        output s,
        output sw,
        output cnt
    );
endinterface

// File: rtl/mux_sel_seq.sv
// Select-line sequencer for a 2:1 mux: time-shares s between channels a and b with a fixed
// dwell, skips idle channels, and supports freeze (hold) and disable (en).
module mux_sel_seq #(
    parameter int DWELL = 20,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_sel_seq_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL_A = 2'd1,
        SEL_B = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          s_reg, s_next;
    logic          sw_reg;
    logic          own_req, oth_req;

    // Requests seen from the point of view of the channel currently selected.
    assign own_req = (state_reg == SEL_B) ? bus.req_b : bus.req_a;
    assign oth_req = (state_reg == SEL_B) ? bus.req_a : bus.req_b;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        s_next     = s_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus.req_a) begin
                    state_next = SEL_A;
                    s_next     = 1'b0;
                end else if (bus.req_b) begin
                    state_next = SEL_B;
                    s_next     = 1'b1;
                end
            end
            SEL_A, SEL_B: begin
                if (cnt_reg == LAST || !own_req) begin
                    // Dwell over (or abandoned): other channel wins, else renew, else park.
                    cnt_next = '0;
                    if (oth_req) begin
                        state_next = (state_reg == SEL_A) ? SEL_B : SEL_A;
                        s_next     = (state_reg == SEL_A);
                    end else if (!own_req) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            s_reg     <= 1'b0;
            sw_reg    <= 1'b0;
        end else if (!bus.en) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sw_reg    <= 1'b0;
        end else if (bus.hold) begin
            sw_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
            sw_reg    <= (s_next != s_reg);
        end
    end

    assign bus.s   = s_reg;
    assign bus.sw  = sw_reg;
    assign bus.cnt = cnt_reg;
endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed bench for mux_sel_seq with DWELL=4: a vector table walked edge by edge,
// plus hand-written asynchronous reset sequences.
module tb_mux_sel_seq;
    localparam int DWELL = 4;
    localparam int CW    = 8;

    logic clk;
    logic rst;

    mux_sel_seq_if #(.CW(CW)) bus ();

    mux_sel_seq #(.DWELL(DWELL), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       hold;
        logic       req_a;
        logic       req_b;
        logic       exp_s;
        logic       exp_sw;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic en, input logic hold, input logic a, input logic b,
                       input logic s, input logic sw, input int c);
        vec_t v;
        v.en = en; v.hold = hold; v.req_a = a; v.req_b = b;
        v.exp_s = s; v.exp_sw = sw; v.exp_cnt = 8'(c);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic s,
                                 input logic sw, input logic [7:0] c);
        check({tag, ".s"},   idx, 8'(bus.s),  8'(s));
        check({tag, ".sw"},  idx, 8'(bus.sw), 8'(sw));
        check({tag, ".cnt"}, idx, bus.cnt,    c);
        $display("%s %0d: s=%0b sw=%0b cnt=%0d", tag, idx, bus.s, bus.sw, bus.cnt);
    endtask

    task automatic drive(input logic en, input logic hold, input logic a, input logic b);
        bus.en = en; bus.hold = hold; bus.req_a = a; bus.req_b = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Round robin from IDLE
        add(1,0,1,1, 0,0,0); add(1,0,1,1, 0,0,1); add(1,0,1,1, 0,0,2); add(1,0,1,1, 0,0,3);
        add(1,0,1,1, 1,1,0); add(1,0,1,1, 1,0,1); add(1,0,1,1, 1,0,2); add(1,0,1,1, 1,0,3);
        add(1,0,1,1, 0,1,0);
        // Hold three cycles at cnt=2: switch delayed by three edges
        add(1,0,1,1, 0,0,1); add(1,0,1,1, 0,0,2);
        add(1,1,1,1, 0,0,2); add(1,1,1,1, 0,0,2); add(1,1,1,1, 0,0,2);
        add(1,0,1,1, 0,0,3); add(1,0,1,1, 1,1,0);
        // SEL_B up to cnt=3, then disable, then re-enable with req_b only
        add(1,0,1,1, 1,0,1); add(1,0,1,1, 1,0,2); add(1,0,1,1, 1,0,3);
        add(0,0,1,1, 1,0,0);
        add(1,0,0,1, 1,0,0); add(1,0,0,1, 1,0,1); add(1,0,0,1, 1,0,2); add(1,0,0,1, 1,0,3);
        add(1,0,0,1, 1,0,0);
        // Own request dropped with other requesting: immediate switch to a
        add(1,0,1,0, 0,1,0); add(1,0,1,1, 0,0,1);
        // Early release at cnt=1 in SEL_A
        add(1,0,0,1, 1,1,0);
        // No requests: IDLE keeps s; entry into opposite channel pulses sw
        add(1,0,0,0, 1,0,0); add(1,0,1,0, 0,1,0); add(1,0,1,1, 0,0,1);
        // Disable outranks hold
        add(0,1,1,1, 0,0,0);
        // Single channel b from IDLE with s=0
        add(1,0,0,1, 1,1,0); add(1,0,0,1, 1,0,1); add(1,0,0,1, 1,0,2); add(1,0,0,1, 1,0,3);
        add(1,0,0,1, 1,0,0); add(1,0,0,1, 1,0,1);

        rst = 1'b1;
        drive(0, 0, 0, 0);
        #1;
        check_outputs("reset", 0, 1'b0, 1'b0, 8'd0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].hold, vecs[i].req_a, vecs[i].req_b);
            step();
            check_outputs("vec", i, vecs[i].exp_s, vecs[i].exp_sw, vecs[i].exp_cnt);
        end

        // Asynchronous reset mid-dwell in SEL_A at cnt=2
        drive(0, 0, 0, 0);
        step();
        drive(1, 0, 1, 1);
        step();
        step();
        step();
        check_outputs("pre_rst", 0, 1'b0, 1'b0, 8'd2);
        #2 rst = 1'b1;
        #1 check_outputs("async_rst", 0, 1'b0, 1'b0, 8'd0);
        #1 rst = 1'b0;
        step();
        check_outputs("after_rst", 0, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k < DWELL; k++) begin
            step();
            check_outputs("after_rst", k, 1'b0, 1'b0, 8'(k));
        end
        step();
        check_outputs("after_rst", DWELL, 1'b1, 1'b1, 8'd0);

        // Asynchronous reset while s=1 and sw is pulsing
        #2 rst = 1'b1;
        #1 check_outputs("async_rst", 1, 1'b0, 1'b0, 8'd0);
        #1 rst = 1'b0;
        step();
        check_outputs("after_rst2", 0, 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
